// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice: frame width and
// arbiter FSM state encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: one-hot grant of the first request at or
// after ptr_i, wrapping; any_o flags that at least one request is pending.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          any_o
);

    int            sum_s;
    logic [PW-1:0] idx_s;
    logic          found_s;

    // Scan upward from the pointer, wrapping at N, and keep the first hit.
    always_comb begin
        gnt_o   = '0;
        found_s = 1'b0;
        sum_s   = 0;
        idx_s   = '0;
        for (int i = 0; i < N; i++) begin
            sum_s = int'(ptr_i) + i;
            if (sum_s >= N) begin
                sum_s = sum_s - N;
            end else begin
                sum_s = sum_s;
            end
            idx_s = PW'(sum_s);
            if (!found_s && req_i[idx_s]) begin
                gnt_o[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 UART serializer among NUM_REQ byte streams; round-robin
// grant locked for a whole message, with a single registered output byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = UART_DATA_W,
    parameter int MAX_BURST  = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          tx_valid_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    input  logic                          tx_ready_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);

    localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

    logic [NUM_REQ-1:0]  pick_gnt_s;
    logic                pick_any_s;
    logic                stage_free_s;
    logic                sel_valid_s;
    logic                sel_last_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic [PW-1:0]       owner_idx_s;
    logic [PW-1:0]       next_ptr_s;
    logic                accept_s;
    logic                burst_hit_s;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt_s),
        .any_o (pick_any_s)
    );

    // Mux the owner's byte, flags and index out of the packed request buses.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = '0;
        owner_idx_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_valid_s = sel_valid_s | (grant_q[k] & req_valid_i[k]);
            sel_last_s  = sel_last_s  | (grant_q[k] & req_last_i[k]);
            sel_data_s  = sel_data_s  | ({DATA_WIDTH{grant_q[k]}} & req_data_i[k*DATA_WIDTH +: DATA_WIDTH]);
            owner_idx_s = owner_idx_s | (grant_q[k] ? PW'(k) : PW'(0));
        end
    end

    assign stage_free_s = !tx_valid_q || tx_ready_i;
    assign accept_s     = (state_q == LOCK) && stage_free_s && sel_valid_s;
    assign burst_hit_s  = (MAX_BURST != 0) && (int'(cnt_q) == MAX_BURST - 1);
    assign next_ptr_s   = (owner_idx_s == PW'(NUM_REQ - 1)) ? PW'(0) : owner_idx_s + PW'(1);
    assign req_ready_o  = ((state_q == LOCK) && stage_free_s) ? grant_q : {NUM_REQ{1'b0}};

    // Arbitration FSM, burst counter and the one-entry output stage.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        if (tx_valid_q && tx_ready_i) begin
            tx_valid_d = 1'b0;
        end else begin
            tx_valid_d = tx_valid_q;
        end
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    grant_d = pick_gnt_s;
                    state_d = LOCK;
                end else begin
                    grant_d = '0;
                end
            end
            LOCK: begin
                if (accept_s) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = sel_data_s;
                    if (sel_last_s || burst_hit_s) begin
                        ptr_d   = next_ptr_s;
                        cnt_d   = '0;
                        grant_d = '0;
                        state_d = IDLE;
                    end else if (MAX_BURST != 0) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; reset discards any byte still held for the serializer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
    assign grant_o    = grant_q;
    assign busy_o     = (state_q != IDLE) || tx_valid_q;

endmodule
